// File: rtl/ex_wb_stage_if.sv
// ID/EX -> EX/WB bundle: operand/control inputs from ID/EX plus the write-back,
// forwarding and ID read-port signals returned to the rest of the pipeline.
interface ex_wb_stage_if #(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 3,
    parameter int CNT_W   = 16
);
    logic [DATA_W-1:0]  id_ex_rddata;
    logic [RADDR_W-1:0] id_ex_rs;
    logic [RADDR_W-1:0] id_ex_rd;
    logic               id_ex_regwr;
    logic               id_ex_alusrc;
    logic [RADDR_W-1:0] id_rd_addr;
    logic [DATA_W-1:0]  id_rd_data;
    logic [DATA_W-1:0]  wb_data;
    logic [RADDR_W-1:0] wb_rd;
    logic               wb_regwr;
    logic               fwd_a;
    logic               fwd_b;
    logic [CNT_W-1:0]   retire_cnt;

    modport master (
        output id_ex_rddata, id_ex_rs, id_ex_rd, id_ex_regwr, id_ex_alusrc, id_rd_addr,
        input  id_rd_data, wb_data, wb_rd, wb_regwr, fwd_a, fwd_b, retire_cnt
    );

    modport slave (
        input  id_ex_rddata, id_ex_rs, id_ex_rd, id_ex_regwr, id_ex_alusrc, id_rd_addr,
        output id_rd_data, wb_data, wb_rd, wb_regwr, fwd_a, fwd_b, retire_cnt
    );
endinterface

// File: rtl/ex_wb_stage.sv
// EX stage with EX/WB register and write-back register file; forwards the EX/WB
// result into EX and writes it through to the ID-stage read port.
module ex_wb_stage #(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic          clock,
    input  logic          reset,
    ex_wb_stage_if.slave  bus
);
    localparam int NUM_REGS = 2**RADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] rf_q;
    logic [DATA_W-1:0]               wb_data_q, wb_data_d;
    logic [RADDR_W-1:0]              wb_rd_q,   wb_rd_d;
    logic                            wb_regwr_q, wb_regwr_d;
    logic [CNT_W-1:0]                retire_q;

    logic              fwd_a, fwd_b;
    logic [DATA_W-1:0] op_a, op_b;

    // Forwarding is gated by wb_regwr so a non-writing instruction never bypasses.
    always_comb begin
        fwd_a = wb_regwr_q && (wb_rd_q == bus.id_ex_rs);
        fwd_b = !bus.id_ex_alusrc && wb_regwr_q && (wb_rd_q == bus.id_ex_rd);
        op_a  = fwd_a ? wb_data_q : rf_q[bus.id_ex_rs];
        op_b  = fwd_b ? wb_data_q : bus.id_ex_rddata;
        wb_data_d  = bus.id_ex_alusrc ? bus.id_ex_rddata : op_a + op_b;
        wb_rd_d    = bus.id_ex_rd;
        wb_regwr_d = bus.id_ex_regwr;
    end

    // rf write uses the pre-edge EX/WB contents while EX/WB reloads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_q       <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_regwr_q <= 1'b0;
            retire_q   <= '0;
        end else begin
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_regwr_q <= wb_regwr_d;
            if (wb_regwr_q) begin
                rf_q[wb_rd_q] <= wb_data_q;
                retire_q      <= retire_q + CNT_W'(1);
            end
        end
    end

    assign bus.id_rd_data = (wb_regwr_q && (wb_rd_q == bus.id_rd_addr)) ? wb_data_q
                                                                        : rf_q[bus.id_rd_addr];
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_regwr   = wb_regwr_q;
    assign bus.fwd_a      = fwd_a;
    assign bus.fwd_b      = fwd_b;
    assign bus.retire_cnt = retire_q;
endmodule
